// File: rtl/mips_controller.sv
// mips_controller: multicycle control FSM for the 8-bit MIPS datapath (LB, SB, R-type, BEQ, J)
// Ports: clk/reset (sync, active-high); op, funct, zero from the datapath;
//   memread, memwrite, alusrca, alusrcb, pcsource, iord, irwrite, memtoreg, regdst, regwrite,
//   pcen and alucontrol drive the same-named datapath inputs; instr_done pulses on the last
//   cycle of each instruction.
// Option: define ADDI_EN to add ADDI (op 001000) via ADDIEX/ADDIWR; otherwise it is an illegal op.
module mips_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       instr_done
);
  typedef enum logic [STATE_W-1:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX
`ifdef ADDI_EN
    , ADDIEX, ADDIWR
`endif
  } state_t;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif
  state_t state_q, state_d;
  always_ff @(posedge clk) state_q <= reset ? FETCH1 : state_d;
  always_comb begin
    state_d    = FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    iord       = 1'b0;
    irwrite    = 4'b0000;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    pcen       = 1'b0;
    alucontrol = 3'b010;
    instr_done = 1'b0;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcen    = 1'b1;
        irwrite = state_q == FETCH1 ? 4'b0001 : state_q == FETCH2 ? 4'b0010 :
                  state_q == FETCH3 ? 4'b0100 : 4'b1000;
        state_d = state_q == FETCH1 ? FETCH2 : state_q == FETCH2 ? FETCH3 :
                  state_q == FETCH3 ? FETCH4 : DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        state_d = (op == OP_LB || op == OP_SB) ? MEMADR : op == OP_R ? RTYPEEX :
                  op == OP_BEQ ? BEQEX : op == OP_J ? JEX : FETCH1;
`ifdef ADDI_EN
        if (op == OP_ADDI) state_d = ADDIEX;
`endif
        // illegal opcodes retire here with no side effects
        instr_done = state_d == FETCH1;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = op == OP_LB ? LBRD : SBWR;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = LBWR;
      end
      LBWR: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      SBWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct == 6'b100000 ? 3'b010 : funct == 6'b100010 ? 3'b110 :
                     funct == 6'b100100 ? 3'b000 : funct == 6'b100101 ? 3'b001 :
                     funct == 6'b101010 ? 3'b111 : 3'b101;
        state_d    = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsource   = 2'b01;
        pcen       = zero;
        instr_done = 1'b1;
      end
      JEX: begin
        pcsource   = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWR;
      end
      ADDIWR: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
    // reset blocks every side effect in the cycle it is asserted
    if (reset) begin
      irwrite    = 4'b0000;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      memread    = 1'b0;
      instr_done = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller: randomized scoreboard bench for mips_controller
module tb_mips_controller;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       instr_done;
  } ctl_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen, instr_done;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;
  ctl_t act;
  ctl_t exp_q[$];
  string nm_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsource(pcsource), .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .pcen(pcen), .alucontrol(alucontrol),
    .instr_done(instr_done)
  );
  always #5 clk = ~clk;
  assign act = {memread, memwrite, alusrca, alusrcb, pcsource, iord, irwrite,
                memtoreg, regdst, regwrite, pcen, alucontrol, instr_done};
  always @(negedge clk) begin
    n_cmp++;
    if ((memread && memwrite) || !$onehot0(irwrite)) begin
      n_bad++;
      $display("FAIL invariant: memread=%b memwrite=%b irwrite=%b", memread, memwrite, irwrite);
    end
    if (exp_q.size() > 0) begin
      ctl_t e;
      string nm;
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end
  function automatic ctl_t dflt();
    ctl_t c = '0;
    c.alucontrol = 3'b010;
    return c;
  endfunction
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction
  function automatic bit is_legal(input logic [5:0] o);
`ifdef ADDI_EN
    if (o == 6'b001000) return 1'b1;
`endif
    return o == 6'b100000 || o == 6'b101000 || o == 6'b000000 || o == 6'b000100 || o == 6'b000010;
  endfunction
  task automatic push(input ctl_t c, input string nm);
    exp_q.push_back(c);
    nm_q.push_back(nm);
  endtask
  task automatic push_fetch(input string t);
    ctl_t c;
    for (int k = 0; k < 4; k++) begin
      c = dflt();
      c.memread = 1'b1;
      c.irwrite = 4'b0001 << k;
      c.alusrcb = 2'b01;
      c.pcen = 1'b1;
      push(c, $sformatf("%s.fetch%0d", t, k + 1));
    end
  endtask
  task automatic push_front_end(input logic [5:0] o, input string t);
    ctl_t c;
    push_fetch(t);
    c = dflt();
    c.alusrcb = 2'b11;
    c.instr_done = !is_legal(o);
    push(c, {t, ".decode"});
  endtask
  task automatic push_memadr(input string t);
    ctl_t c = dflt();
    c.alusrca = 1'b1;
    c.alusrcb = 2'b10;
    push(c, {t, ".memadr"});
  endtask
  // expected per-cycle outputs for one whole instruction; returns its cycle count
  task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z, output int n);
    ctl_t c;
    string t = $sformatf("op%06b_f%06b_z%0d", o, f, z);
    push_front_end(o, t);
    n = 5;
    c = dflt();
    if (o == 6'b100000) begin
      push_memadr(t);
      c.memread = 1'b1; c.iord = 1'b1;
      push(c, {t, ".lbrd"});
      c = dflt();
      c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1;
      push(c, {t, ".lbwr"});
      n = 8;
    end else if (o == 6'b101000) begin
      push_memadr(t);
      c.memwrite = 1'b1; c.iord = 1'b1; c.instr_done = 1'b1;
      push(c, {t, ".sbwr"});
      n = 7;
    end else if (o == 6'b000000) begin
      c.alusrca = 1'b1; c.alucontrol = alu_of(f);
      push(c, {t, ".rex"});
      c = dflt();
      c.regwrite = 1'b1; c.regdst = 1'b1; c.instr_done = 1'b1;
      push(c, {t, ".rwr"});
      n = 7;
    end else if (o == 6'b000100) begin
      c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsource = 2'b01; c.pcen = z; c.instr_done = 1'b1;
      push(c, {t, ".beq"});
      n = 6;
    end else if (o == 6'b000010) begin
      c.pcsource = 2'b10; c.pcen = 1'b1; c.instr_done = 1'b1;
      push(c, {t, ".j"});
      n = 6;
    end else if (is_legal(o)) begin
      c.alusrca = 1'b1; c.alusrcb = 2'b10;
      push(c, {t, ".addiex"});
      c = dflt();
      c.regwrite = 1'b1; c.instr_done = 1'b1;
      push(c, {t, ".addiwr"});
      n = 7;
    end
  endtask
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z);
    int n;
    op = o;
    funct = f;
    zero = z;
    model(o, f, z, n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    ctl_t c;
    int r;
    @(posedge clk);
    #1;
    c = dflt();
    c.alusrcb = 2'b01;
    push(c, "reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(6'b000000, 6'b100010, 1'b0);
    run(6'b100000, 6'b000000, 1'b0);
    run(6'b101000, 6'b000000, 1'b0);
    run(6'b000100, 6'b000000, 1'b1);
    run(6'b000100, 6'b000000, 1'b0);
    run(6'b000010, 6'b000000, 1'b0);
    run(6'b111111, 6'b000000, 1'b1);
    run(6'b001000, 6'b000000, 1'b0);
    op = 6'b100000;
    push_front_end(op, "lb_abort");
    push_memadr("lb_abort");
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    c = dflt();
    c.iord = 1'b1;
    push(c, "lb_abort.lbrd_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(6'b000000, 6'b101010, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [5:0] o, f;
      r = $urandom_range(0, 7);
      o = r == 0 ? 6'b100000 : r == 1 ? 6'b101000 : r == 2 ? 6'b000000 : r == 3 ? 6'b000100 :
          r == 4 ? 6'b000010 : r == 5 ? 6'b001000 : 6'($urandom);
      r = $urandom_range(0, 5);
      f = r == 0 ? 6'b100000 : r == 1 ? 6'b100010 : r == 2 ? 6'b100100 : r == 3 ? 6'b100101 :
          r == 4 ? 6'b101010 : 6'($urandom);
      run(o, f, 1'($urandom));
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
